// File: rtl/pc_fetch_ctrl.sv
// IF-stage fetch sequencer: drives the PC register, issues one imem request at a time and drops stale responses.
// Optional build macro PC_FETCH_ALIGN_CHECK_EN enables redirect-target alignment checking and clearing.
module pc_fetch_ctrl #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_reg,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  pc_stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic                  pipe_stall,
  input  logic                  trap_valid,
  input  logic [ADDR_WIDTH-1:0] trap_target,
  input  logic                  br_valid,
  input  logic [ADDR_WIDTH-1:0] br_target,
  input  logic                  jmp_valid,
  input  logic [ADDR_WIDTH-1:0] jmp_target,
  output logic                  fetch_valid,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  flush,
  output logic                  misalign_err
);

  localparam logic [ADDR_WIDTH-1:0] PC_INC = ADDR_WIDTH'(INSTR_BYTES);

  typedef enum logic [2:0] {BOOT, REQ, RESP, HOLD, DRAIN} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic                    stale_reg, stale_next;
  logic                    redirect;
  logic                    enter_req;
  logic [ADDR_WIDTH-1:0]   raw_target;
  logic [ADDR_WIDTH-1:0]   redir_target;

  always_comb begin
    redirect   = trap_valid | br_valid | jmp_valid;
    raw_target = trap_valid ? trap_target :
                 br_valid   ? br_target   : jmp_target;
  end

`ifdef PC_FETCH_ALIGN_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
  assign misalign_err = redirect & (|(raw_target & ALIGN_MASK));
  assign redir_target = raw_target & ~ALIGN_MASK;
`else
  assign misalign_err = 1'b0;
  assign redir_target = raw_target;
`endif

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    stale_next  = stale_reg;
    pc_next     = '0;
    pc_stall    = 1'b1;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    enter_req   = 1'b0;

    if (redirect) begin
      pc_next  = redir_target;
      pc_stall = 1'b0;
      flush    = 1'b1;
    end

    case (state_reg)
      BOOT: begin
        state_next = REQ;
        enter_req  = 1'b1;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          state_next = (stale_reg || redirect) ? DRAIN : RESP;
          stale_next = 1'b0;
        end else if (redirect) begin
          stale_next = 1'b1;
        end
      end
      RESP: begin
        if (redirect) begin
          // A response arriving with the redirect is simply dropped; nothing left to drain.
          if (imem_rvalid) begin
            state_next = REQ;
            enter_req  = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end else if (imem_rvalid) begin
          fetch_valid = 1'b1;
          if (!pipe_stall) begin
            pc_stall   = 1'b0;
            pc_next    = pc_reg + PC_INC;
            state_next = REQ;
            enter_req  = 1'b1;
          end else begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          state_next = REQ;
          enter_req  = 1'b1;
        end else begin
          fetch_valid = 1'b1;
          if (!pipe_stall) begin
            pc_stall   = 1'b0;
            pc_next    = pc_reg + PC_INC;
            state_next = REQ;
            enter_req  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (imem_rvalid) begin
          state_next = REQ;
          enter_req  = 1'b1;
        end
      end
      default: state_next = BOOT;
    endcase

    // The PC register updates on the same edge, so latch the value it is about to hold.
    if (enter_req) begin
      addr_next = pc_stall ? pc_reg : pc_next;
    end
  end

  assign imem_addr = imem_req    ? addr_reg : '0;
  assign fetch_pc  = fetch_valid ? addr_reg : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= BOOT;
      addr_reg  <= '0;
      stale_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      stale_reg <= stale_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: acts as PC register and imem, queues expected fetch addresses and PCs.
module tb_pc_fetch_ctrl;
  localparam int AW = 64;

  logic          clk;
  logic          reset;
  logic [AW-1:0] pc_reg;
  logic [AW-1:0] pc_next;
  logic          pc_stall;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic          pipe_stall;
  logic          trap_valid, br_valid, jmp_valid;
  logic [AW-1:0] trap_target, br_target, jmp_target;
  logic          fetch_valid;
  logic [AW-1:0] fetch_pc;
  logic          flush;
  logic          misalign_err;

  logic [AW-1:0] pc_init;
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] exp_fetch_q[$];
  logic [AW-1:0] exp_v;
  logic [AW-1:0] exp_tgt;
  logic          exp_mis;
  int            cmp_count;
  int            err_count;

  pc_fetch_ctrl #(.ADDR_WIDTH(AW), .INSTR_BYTES(4)) dut (
    .clk(clk), .reset(reset), .pc_reg(pc_reg), .pc_next(pc_next), .pc_stall(pc_stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .pipe_stall(pipe_stall), .trap_valid(trap_valid), .trap_target(trap_target),
    .br_valid(br_valid), .br_target(br_target), .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .flush(flush), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_reg <= pc_init;
    else if (!pc_stall) pc_reg <= pc_next;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic g, input logic rv, input logic ps,
                       input logic tv, input logic bv, input logic jv);
    imem_gnt    = g;
    imem_rvalid = rv;
    pipe_stall  = ps;
    trap_valid  = tv;
    br_valid    = bv;
    jmp_valid   = jv;
    #1;
  endtask

  task automatic test_reset();
    pc_init = '0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    tick();
    tick();
    cmp_count++;
    if (pc_stall !== 1'b1) begin err_count++; $display("FAIL reset_pc_stall: got %b expected 1", pc_stall); end
    cmp_count++;
    if ({imem_req, fetch_valid, flush, misalign_err} !== 4'b0) begin
      err_count++; $display("FAIL reset_flags: got %b expected 0000", {imem_req, fetch_valid, flush, misalign_err});
    end
    cmp_count++;
    if ((pc_next | imem_addr | fetch_pc) !== '0) begin
      err_count++; $display("FAIL reset_buses: pc_next=%h imem_addr=%h fetch_pc=%h expected 0", pc_next, imem_addr, fetch_pc);
    end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    cmp_count++;
    if (pc_stall !== 1'b1 || imem_req !== 1'b0) begin
      err_count++; $display("FAIL boot_state: pc_stall=%b imem_req=%b expected 1/0", pc_stall, imem_req);
    end
  endtask

  task automatic test_sequential();
    exp_addr_q.push_back(64'h0); exp_addr_q.push_back(64'h4); exp_addr_q.push_back(64'h8);
    exp_fetch_q.push_back(64'h0); exp_fetch_q.push_back(64'h4); exp_fetch_q.push_back(64'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1, 0, 0, 0, 0, 0);
      exp_v = exp_addr_q.pop_front();
      cmp_count++;
      if (imem_req !== 1'b1 || imem_addr !== exp_v) begin
        err_count++; $display("FAIL seq_req: req=%b addr=%h expected 1/%h", imem_req, imem_addr, exp_v);
      end
      cmp_count++;
      if (fetch_valid !== 1'b0) begin err_count++; $display("FAIL seq_gap: fetch_valid=%b expected 0", fetch_valid); end
      tick();
      drive(0, 1, 0, 0, 0, 0);
      exp_v = exp_fetch_q.pop_front();
      cmp_count++;
      if (fetch_valid !== 1'b1 || fetch_pc !== exp_v) begin
        err_count++; $display("FAIL seq_fetch: valid=%b pc=%h expected 1/%h", fetch_valid, fetch_pc, exp_v);
      end
      cmp_count++;
      if (pc_stall !== 1'b0 || pc_next !== exp_v + 64'd4) begin
        err_count++; $display("FAIL seq_advance: stall=%b pc_next=%h expected 0/%h", pc_stall, pc_next, exp_v + 64'd4);
      end
      $display("fetch seq pc=%h", fetch_pc);
    end
  endtask

  task automatic test_hold();
    exp_addr_q.push_back(64'hc); exp_addr_q.push_back(64'h10);
    exp_fetch_q.push_back(64'hc); exp_fetch_q.push_back(64'h10);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    exp_v = exp_addr_q.pop_front();
    cmp_count++;
    if (imem_addr !== exp_v) begin err_count++; $display("FAIL hold_addr0: got %h expected %h", imem_addr, exp_v); end
    tick();
    drive(0, 1, 0, 0, 0, 0);
    exp_v = exp_fetch_q.pop_front();
    cmp_count++;
    if (fetch_valid !== 1'b1 || fetch_pc !== exp_v) begin
      err_count++; $display("FAIL hold_fetch0: valid=%b pc=%h expected 1/%h", fetch_valid, fetch_pc, exp_v);
    end
    $display("fetch hold pc=%h", fetch_pc);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    exp_v = exp_addr_q.pop_front();
    cmp_count++;
    if (imem_addr !== exp_v) begin err_count++; $display("FAIL hold_addr1: got %h expected %h", imem_addr, exp_v); end
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(0, (i == 0), 1, 0, 0, 0);
      cmp_count++;
      if (fetch_valid !== 1'b1 || fetch_pc !== exp_fetch_q[0] || pc_stall !== 1'b1) begin
        err_count++; $display("FAIL hold_stall%0d: valid=%b pc=%h stall=%b expected 1/%h/1",
                              i, fetch_valid, fetch_pc, pc_stall, exp_fetch_q[0]);
      end
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    exp_v = exp_fetch_q.pop_front();
    cmp_count++;
    if (fetch_valid !== 1'b1 || fetch_pc !== exp_v) begin
      err_count++; $display("FAIL hold_release: valid=%b pc=%h expected 1/%h", fetch_valid, fetch_pc, exp_v);
    end
    cmp_count++;
    if (pc_stall !== 1'b0 || pc_next !== 64'h14) begin
      err_count++; $display("FAIL hold_advance: stall=%b pc_next=%h expected 0/14", pc_stall, pc_next);
    end
    $display("fetch hold pc=%h", fetch_pc);
  endtask

  task automatic test_branch();
    exp_addr_q.push_back(64'h14); exp_addr_q.push_back(64'h100);
    exp_fetch_q.push_back(64'h100);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    exp_v = exp_addr_q.pop_front();
    cmp_count++;
    if (imem_addr !== exp_v) begin err_count++; $display("FAIL br_addr0: got %h expected %h", imem_addr, exp_v); end
    tick();
    br_target = 64'h100;
    drive(0, 0, 0, 0, 1, 0);
    cmp_count++;
    if (flush !== 1'b1 || pc_next !== 64'h100 || pc_stall !== 1'b0 || fetch_valid !== 1'b0) begin
      err_count++; $display("FAIL br_redirect: flush=%b pc_next=%h stall=%b valid=%b expected 1/100/0/0",
                            flush, pc_next, pc_stall, fetch_valid);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    cmp_count++;
    if (flush !== 1'b0 || pc_stall !== 1'b1 || imem_req !== 1'b0) begin
      err_count++; $display("FAIL br_drain: flush=%b stall=%b req=%b expected 0/1/0", flush, pc_stall, imem_req);
    end
    tick();
    drive(0, 1, 0, 0, 0, 0);
    cmp_count++;
    if (fetch_valid !== 1'b0) begin err_count++; $display("FAIL br_drop: fetch_valid=%b expected 0", fetch_valid); end
    tick();
    drive(1, 0, 0, 0, 0, 0);
    exp_v = exp_addr_q.pop_front();
    cmp_count++;
    if (imem_req !== 1'b1 || imem_addr !== exp_v) begin
      err_count++; $display("FAIL br_newaddr: req=%b addr=%h expected 1/%h", imem_req, imem_addr, exp_v);
    end
    tick();
    drive(0, 1, 0, 0, 0, 0);
    exp_v = exp_fetch_q.pop_front();
    cmp_count++;
    if (fetch_valid !== 1'b1 || fetch_pc !== exp_v || pc_next !== 64'h104) begin
      err_count++; $display("FAIL br_fetch: valid=%b pc=%h pc_next=%h expected 1/%h/104", fetch_valid, fetch_pc, pc_next, exp_v);
    end
    $display("fetch branch pc=%h", fetch_pc);
  endtask

  task automatic test_priority();
    exp_addr_q.push_back(64'h104); exp_addr_q.push_back(64'h200);
    exp_fetch_q.push_back(64'h200);
    tick();
    trap_target = 64'h200; br_target = 64'h300; jmp_target = 64'h400;
    drive(1, 0, 0, 1, 1, 1);
    exp_v = exp_addr_q.pop_front();
    cmp_count++;
    if (imem_addr !== exp_v) begin err_count++; $display("FAIL prio_addr: got %h expected %h", imem_addr, exp_v); end
    cmp_count++;
    if (flush !== 1'b1 || pc_next !== 64'h200) begin
      err_count++; $display("FAIL prio_target: flush=%b pc_next=%h expected 1/200", flush, pc_next);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    cmp_count++;
    if (flush !== 1'b0) begin err_count++; $display("FAIL prio_single_pulse: flush=%b expected 0", flush); end
    tick();
    drive(0, 1, 0, 0, 0, 0);
    cmp_count++;
    if (fetch_valid !== 1'b0) begin err_count++; $display("FAIL prio_drop: fetch_valid=%b expected 0", fetch_valid); end
    tick();
    drive(1, 0, 0, 0, 0, 0);
    exp_v = exp_addr_q.pop_front();
    cmp_count++;
    if (imem_addr !== exp_v) begin err_count++; $display("FAIL prio_newaddr: got %h expected %h", imem_addr, exp_v); end
    tick();
    drive(0, 1, 0, 0, 0, 0);
    exp_v = exp_fetch_q.pop_front();
    cmp_count++;
    if (fetch_valid !== 1'b1 || fetch_pc !== exp_v) begin
      err_count++; $display("FAIL prio_fetch: valid=%b pc=%h expected 1/%h", fetch_valid, fetch_pc, exp_v);
    end
    $display("fetch prio pc=%h", fetch_pc);
  endtask

  task automatic test_jump_stale();
    exp_addr_q.push_back(64'h204); exp_addr_q.push_back(64'h80);
    exp_fetch_q.push_back(64'h80);
    tick();
    jmp_target = 64'h80;
    drive(0, 0, 0, 0, 0, 1);
    cmp_count++;
    if (imem_req !== 1'b1 || imem_addr !== exp_addr_q[0] || flush !== 1'b1 || pc_next !== 64'h80) begin
      err_count++; $display("FAIL jmp_redirect: req=%b addr=%h flush=%b pc_next=%h expected 1/%h/1/80",
                            imem_req, imem_addr, flush, pc_next, exp_addr_q[0]);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    cmp_count++;
    if (imem_req !== 1'b1 || imem_addr !== exp_addr_q[0] || flush !== 1'b0) begin
      err_count++; $display("FAIL jmp_stable: req=%b addr=%h flush=%b expected 1/%h/0", imem_req, imem_addr, flush, exp_addr_q[0]);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0);
    exp_v = exp_addr_q.pop_front();
    cmp_count++;
    if (imem_addr !== exp_v) begin err_count++; $display("FAIL jmp_gnt_addr: got %h expected %h", imem_addr, exp_v); end
    tick();
    drive(0, 1, 0, 0, 0, 0);
    cmp_count++;
    if (fetch_valid !== 1'b0) begin err_count++; $display("FAIL jmp_drop: fetch_valid=%b expected 0", fetch_valid); end
    tick();
    drive(1, 0, 0, 0, 0, 0);
    exp_v = exp_addr_q.pop_front();
    cmp_count++;
    if (imem_addr !== exp_v) begin err_count++; $display("FAIL jmp_newaddr: got %h expected %h", imem_addr, exp_v); end
    tick();
    drive(0, 1, 0, 0, 0, 0);
    exp_v = exp_fetch_q.pop_front();
    cmp_count++;
    if (fetch_valid !== 1'b1 || fetch_pc !== exp_v || pc_next !== 64'h84) begin
      err_count++; $display("FAIL jmp_fetch: valid=%b pc=%h pc_next=%h expected 1/%h/84", fetch_valid, fetch_pc, pc_next, exp_v);
    end
    $display("fetch jump pc=%h", fetch_pc);
  endtask

  task automatic test_misalign();
`ifdef PC_FETCH_ALIGN_CHECK_EN
    exp_tgt = 64'h100; exp_mis = 1'b1;
`else
    exp_tgt = 64'h102; exp_mis = 1'b0;
`endif
    exp_addr_q.push_back(64'h84); exp_addr_q.push_back(exp_tgt);
    exp_fetch_q.push_back(exp_tgt);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    exp_v = exp_addr_q.pop_front();
    cmp_count++;
    if (imem_addr !== exp_v) begin err_count++; $display("FAIL mis_addr0: got %h expected %h", imem_addr, exp_v); end
    tick();
    br_target = 64'h102;
    drive(0, 0, 0, 0, 1, 0);
    cmp_count++;
    if (misalign_err !== exp_mis || pc_next !== exp_tgt || flush !== 1'b1) begin
      err_count++; $display("FAIL mis_redirect: err=%b pc_next=%h flush=%b expected %b/%h/1",
                            misalign_err, pc_next, flush, exp_mis, exp_tgt);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    cmp_count++;
    if (misalign_err !== 1'b0) begin err_count++; $display("FAIL mis_pulse: err=%b expected 0", misalign_err); end
    tick();
    drive(0, 1, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    exp_v = exp_addr_q.pop_front();
    cmp_count++;
    if (imem_addr !== exp_v) begin err_count++; $display("FAIL mis_newaddr: got %h expected %h", imem_addr, exp_v); end
    tick();
    drive(0, 1, 0, 0, 0, 0);
    exp_v = exp_fetch_q.pop_front();
    cmp_count++;
    if (fetch_valid !== 1'b1 || fetch_pc !== exp_v) begin
      err_count++; $display("FAIL mis_fetch: valid=%b pc=%h expected 1/%h", fetch_valid, fetch_pc, exp_v);
    end
    $display("fetch misalign pc=%h", fetch_pc);
  endtask

  task automatic test_redirect_with_rvalid();
    exp_addr_q.push_back(exp_tgt + 64'd4); exp_addr_q.push_back(64'h40);
    exp_fetch_q.push_back(64'h40);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    exp_v = exp_addr_q.pop_front();
    cmp_count++;
    if (imem_addr !== exp_v) begin err_count++; $display("FAIL rvr_addr0: got %h expected %h", imem_addr, exp_v); end
    tick();
    jmp_target = 64'h40;
    drive(0, 1, 0, 0, 0, 1);
    cmp_count++;
    if (fetch_valid !== 1'b0 || flush !== 1'b1 || pc_next !== 64'h40) begin
      err_count++; $display("FAIL rvr_discard: valid=%b flush=%b pc_next=%h expected 0/1/40", fetch_valid, flush, pc_next);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0);
    exp_v = exp_addr_q.pop_front();
    cmp_count++;
    if (imem_req !== 1'b1 || imem_addr !== exp_v) begin
      err_count++; $display("FAIL rvr_newaddr: req=%b addr=%h expected 1/%h", imem_req, imem_addr, exp_v);
    end
    tick();
    drive(0, 1, 0, 0, 0, 0);
    exp_v = exp_fetch_q.pop_front();
    cmp_count++;
    if (fetch_valid !== 1'b1 || fetch_pc !== exp_v) begin
      err_count++; $display("FAIL rvr_fetch: valid=%b pc=%h expected 1/%h", fetch_valid, fetch_pc, exp_v);
    end
    $display("fetch rvr pc=%h", fetch_pc);
  endtask

  task automatic test_reset_wrap();
    exp_addr_q.push_back(64'h44); exp_addr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_fetch_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    exp_v = exp_addr_q.pop_front();
    cmp_count++;
    if (imem_addr !== exp_v) begin err_count++; $display("FAIL wrap_addr0: got %h expected %h", imem_addr, exp_v); end
    tick();
    pc_init = 64'hFFFF_FFFF_FFFF_FFFC;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    cmp_count++;
    if (pc_stall !== 1'b1 || imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
      err_count++; $display("FAIL midreset: stall=%b req=%b valid=%b expected 1/0/0", pc_stall, imem_req, fetch_valid);
    end
    tick();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    exp_v = exp_addr_q.pop_front();
    cmp_count++;
    if (imem_req !== 1'b1 || imem_addr !== exp_v) begin
      err_count++; $display("FAIL wrap_addr: req=%b addr=%h expected 1/%h", imem_req, imem_addr, exp_v);
    end
    tick();
    drive(0, 1, 0, 0, 0, 0);
    exp_v = exp_fetch_q.pop_front();
    cmp_count++;
    if (fetch_valid !== 1'b1 || fetch_pc !== exp_v || pc_next !== 64'h0 || pc_stall !== 1'b0) begin
      err_count++; $display("FAIL wrap_fetch: valid=%b pc=%h pc_next=%h stall=%b expected 1/%h/0/0",
                            fetch_valid, fetch_pc, pc_next, pc_stall, exp_v);
    end
    $display("fetch wrap pc=%h", fetch_pc);
  endtask

  initial begin
    cmp_count = 0;
    err_count = 0;
    trap_target = '0; br_target = '0; jmp_target = '0;
    exp_tgt = '0; exp_mis = 1'b0;
    test_reset();
    test_sequential();
    test_hold();
    test_branch();
    test_priority();
    test_jump_stale();
    test_misalign();
    test_redirect_with_rvalid();
    test_reset_wrap();
    cmp_count++;
    if (exp_addr_q.size() != 0 || exp_fetch_q.size() != 0) begin
      err_count++; $display("FAIL scoreboard_drain: addr_q=%0d fetch_q=%0d expected 0/0", exp_addr_q.size(), exp_fetch_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
